// File: rtl/sr_drv_pkg.sv
// Shared types for the RS-latch S/R driver: command opcodes, FSM states, sizing helper.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        OP_CHECK  = 2'b00,
        OP_SET    = 2'b01,
        OP_RESET  = 2'b10,
        OP_TOGGLE = 2'b11
    } sr_op_t;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK,
        GAP
    } sr_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Load/decrement down-counter with a zero flag; sequences the driver's timed states.
module sr_drv_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Command-driven S/R pulse source with Q/QB readback for RS latch characterisation.
// Optional error counter output err_cnt enabled by defining SR_DRV_ERRCNT_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// PULSE  | S (expected 1) or R (expected 0) held high
// SETTLE | S=R=0, latch and synchroniser settling
// CHECK  | compare synchronised Q/QB against expected value
// GAP    | idle spacing before the next command
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W  = 4,
    parameter int SETTLE_W = 2,
    parameter int GAP_W    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       S,
    output logic       R,
    input  logic       q_in,
    input  logic       qb_in,
    output logic       done,
    output logic       err,
    output logic       exp_q
`ifdef SR_DRV_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int CW = $clog2(max3(PULSE_W, SETTLE_W, GAP_W) + 1);
    localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_W - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'((GAP_W > 0) ? GAP_W - 1 : 0);

    sr_state_t       state, state_next;
    logic            exp_r, exp_next;
    logic            q_s1, q_sync, qb_s1, qb_sync;
    logic            tmr_load, tmr_zero;
    logic [CW-1:0]   tmr_val;
    logic            accept;
    sr_op_t          op;

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign op        = sr_op_t'(cmd_op);

    sr_drv_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_next = state;
        exp_next   = exp_r;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_SET:    exp_next = 1'b1;
                        OP_RESET:  exp_next = 1'b0;
                        OP_TOGGLE: exp_next = ~q_sync;
                        default:   exp_next = q_sync;
                    endcase
                    tmr_load = 1'b1;
                    if (op == OP_CHECK) begin
                        state_next = SETTLE;
                        tmr_val    = SETTLE_LD;
                    end else begin
                        state_next = PULSE;
                        tmr_val    = PULSE_LD;
                    end
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_next = SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (tmr_zero)
                    state_next = CHECK;
            end
            CHECK: begin
                if (GAP_W > 0) begin
                    state_next = GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = GAP_LD;
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                if (tmr_zero)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // S/R derive from the next state so the pulse width equals the PULSE dwell exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            exp_r   <= 1'b0;
            S       <= 1'b0;
            R       <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            exp_q   <= 1'b0;
            q_s1    <= 1'b0;
            q_sync  <= 1'b0;
            qb_s1   <= 1'b0;
            qb_sync <= 1'b0;
        end else begin
            state   <= state_next;
            exp_r   <= exp_next;
            S       <= (state_next == PULSE) &&  exp_next;
            R       <= (state_next == PULSE) && !exp_next;
            done    <= (state == CHECK);
            err     <= (state == CHECK) && ((q_sync != exp_r) || (qb_sync == q_sync));
            if (state == CHECK)
                exp_q <= exp_r;
            q_s1    <= q_in;
            q_sync  <= q_s1;
            qb_s1   <= qb_in;
            qb_sync <= qb_s1;
        end
    end

`ifdef SR_DRV_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= 8'd0;
        else if (done && err && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver driving a behavioural RS latch model.
module tb_sr_latch_driver;
    import sr_drv_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready, S, R, q_in, qb_in, done, err, exp_q;
`ifdef SR_DRV_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int total = 0;
    int bad = 0;
    int overlap = 0;
    int acc_cnt = 0;

    logic latch_q = 1'b0;
    logic force_lo = 1'b0;

    sr_latch_driver dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .S         (S),
        .R         (R),
        .q_in      (q_in),
        .qb_in     (qb_in),
        .done      (done),
        .err       (err),
        .exp_q     (exp_q)
`ifdef SR_DRV_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // behavioural RS latch; force_lo emulates a stuck-low Q
    always @(S or R) begin
        if (S && !R)
            latch_q = 1'b1;
        else if (R && !S)
            latch_q = 1'b0;
    end
    assign q_in  = force_lo ? 1'b0 : latch_q;
    assign qb_in = ~q_in;

    always @(negedge clk) begin
        if (S && R) begin
            overlap++;
            $error("FAIL s_r_overlap S=%0b R=%0b", S, R);
        end
    end

    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready)
            acc_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input bit hold, output int w, output int lat,
                           output int s_cnt, output int r_cnt, output logic e);
        w = 0;
        lat = -1;
        e = 1'bx;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        while (!cmd_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        if (!hold)
            cmd_valid = 1'b0;
        s_cnt = int'(S);
        r_cnt = int'(R);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            s_cnt += int'(S);
            r_cnt += int'(R);
            if (done) begin
                lat = k;
                e = err;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        int w, lat, sc, rc, acc0, rnd_bad, want_lat;
        logic e;
        logic [1:0] op;
        bit hold;

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_rst", 32'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_s", 32'(S), 0);
        chk("rst_r", 32'(R), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_exp_q", 32'(exp_q), 0);

        // SET
        run_cmd(OP_SET, 1'b0, w, lat, sc, rc, e);
        chk("set_latency", lat, 7);
        chk("set_s_cycles", sc, 4);
        chk("set_r_cycles", rc, 0);
        chk("set_err", 32'(e), 0);
        chk("set_exp_q", 32'(exp_q), 1);

        // TOGGLE twice from Q=1
        run_cmd(OP_TOGGLE, 1'b0, w, lat, sc, rc, e);
        chk("tog1_r_cycles", rc, 4);
        chk("tog1_s_cycles", sc, 0);
        chk("tog1_err", 32'(e), 0);
        chk("tog1_exp_q", 32'(exp_q), 0);
        run_cmd(OP_TOGGLE, 1'b0, w, lat, sc, rc, e);
        chk("tog2_gap_wait", w, 2);
        chk("tog2_s_cycles", sc, 4);
        chk("tog2_r_cycles", rc, 0);
        chk("tog2_err", 32'(e), 0);
        chk("tog2_exp_q", 32'(exp_q), 1);

        // readback error with Q stuck low
        force_lo = 1'b1;
        run_cmd(OP_SET, 1'b0, w, lat, sc, rc, e);
        chk("stuck_err", 32'(e), 1);
        chk("stuck_exp_q", 32'(exp_q), 1);
`ifdef SR_DRV_ERRCNT_EN
        repeat (2) @(posedge clk);
        #1;
        chk("err_cnt_one", 32'(err_cnt), 1);
        for (int i = 0; i < 255; i++)
            run_cmd(OP_SET, 1'b0, w, lat, sc, rc, e);
        repeat (2) @(posedge clk);
        #1;
        chk("err_cnt_sat", 32'(err_cnt), 255);
`endif
        force_lo = 1'b0;

        // reset in the 2nd PULSE cycle of RESET
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op = OP_RESET;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("abort_r_start", 32'(R), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_r_cut", 32'(R), 0);
        chk("abort_s", 32'(S), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_idle_ready", 32'(cmd_ready), 1);
        chk("abort_exp_q", 32'(exp_q), 0);
        chk("abort_done_after", 32'(done), 0);
        run_cmd(OP_CHECK, 1'b0, w, lat, sc, rc, e);
        chk("check_latency", lat, 3);
        chk("check_err", 32'(e), 0);
        chk("check_no_pulse", sc + rc, 0);

        // random command stream
        acc0 = acc_cnt;
        rnd_bad = 0;
        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd(op, hold, w, lat, sc, rc, e);
            want_lat = (op == OP_CHECK) ? 3 : 7;
            if (e !== 1'b0 || lat != want_lat)
                rnd_bad++;
        end
        chk("rnd_cmd_bad", rnd_bad, 0);
        chk("rnd_accepts", acc_cnt - acc0, 200);
        chk("s_r_overlap_total", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
